// File: rtl/aes_128_pkg.sv
// Shared AES-128 widths and core latency, plus a helper that picks one
// 32-bit word out of a 128-bit block (word 0 is the most significant).
package aes_128_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;
    localparam int AES_CORE_LATENCY    = 11;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

    function automatic aes_word_t aes_word_sel(input aes_block_t blk, input logic [1:0] idx);
        aes_word_t w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = {AES_WORD_W{1'b0}};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous FIFO of 128-bit blocks; push when full and pop when empty are ignored.
module aes_blk_fifo
    import aes_128_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  aes_block_t      i_data,
    output aes_block_t      o_head,
    output logic [CW-1:0]   o_count
);

    aes_block_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + {{(PW-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    assign w_push_ok = i_push && (r_count != CW'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != {CW{1'b0}});
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {AES_BLOCK_W{1'b0}};
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/aes_128_out_serializer.sv
// Tracks real blocks through the stall-free aes_128 pipeline, captures them into a
// small FIFO and streams each block as four 32-bit words with credit-based issue control.
module aes_128_out_serializer
    import aes_128_pkg::*;
#(
    parameter int LATENCY = AES_CORE_LATENCY,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [AES_BLOCK_W-1:0] aes_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [AES_WORD_W-1:0]  word_data,
    output logic                   word_last
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] r_dl;
    logic [CW-1:0]      r_inflight;
    logic [1:0]         r_index;
    logic [CW-1:0]      w_fifo_count;
    aes_block_t         w_head;
    logic [CW:0]        w_committed;
    logic               w_issue;
    logic               w_push;
    logic               w_hs;
    logic               w_pop;

    // Credits count both stored blocks and blocks still inside the core, so a
    // push can never find the FIFO full.
    assign w_committed = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign issue_ready = (w_committed < (CW+1)'(DEPTH));
    assign w_issue     = issue_valid && issue_ready;
    assign w_push      = r_dl[LATENCY-1];
    assign word_valid  = (w_fifo_count != {CW{1'b0}});
    assign word_last   = word_valid && (r_index == 2'd3);
    assign w_hs        = word_valid && word_ready;
    assign w_pop       = w_hs && (r_index == 2'd3);

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (aes_out),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    // Valid delay line mirroring the core pipeline, in-flight count and word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl       <= {LATENCY{1'b0}};
            r_inflight <= {CW{1'b0}};
            r_index    <= 2'd0;
        end else begin
            r_dl <= {r_dl[LATENCY-2:0], w_issue};
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_inflight <= r_inflight - {{(CW-1){1'b0}}, 1'b1};
                default: r_inflight <= r_inflight;
            endcase
            if (w_hs) begin
                r_index <= r_index + 2'd1;
            end else begin
                r_index <= r_index;
            end
        end
    end

    // Word mux from the FIFO head; forced to zero while nothing is stored.
    always_comb begin
        word_data = {AES_WORD_W{1'b0}};
        if (word_valid) begin
            word_data = aes_word_sel(w_head, r_index);
        end else begin
            word_data = {AES_WORD_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_aes_128_out_serializer.sv
// Directed bench for aes_128_out_serializer. The aes_128 core is stood in for by an
// 11-stage delay of known FIPS-197 / KAT ciphertexts driven on core_in.
module tb_aes_128_out_serializer;

    typedef struct {
        logic [127:0] ct;
        logic [31:0]  w0, w1, w2, w3;
    } vec_t;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } ew_t;

    logic         clk;
    logic         rst_n;
    logic         issue_valid;
    logic         issue_ready;
    logic [127:0] aes_out;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word_data;
    logic         word_last;

    logic [127:0] core_in;
    logic [127:0] pipe [0:10];

    vec_t tab [5];
    ew_t  exp_q [$];
    int   n_cmp;
    int   n_err;

    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    aes_128_out_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .aes_out     (aes_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_last   (word_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: no reset, no valid, one result per cycle 11 edges later.
    always @(posedge clk) begin
        pipe[0] <= core_in;
        for (int k = 1; k < 11; k++) pipe[k] <= pipe[k-1];
    end
    assign aes_out = pipe[10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic exp_push(input int idx);
        exp_q.push_back({tab[idx].w0, 1'b0});
        exp_q.push_back({tab[idx].w1, 1'b0});
        exp_q.push_back({tab[idx].w2, 1'b0});
        exp_q.push_back({tab[idx].w3, 1'b1});
    endtask

    // One clock cycle: drive inputs, note whether the issue is accepted, step past the edge.
    task automatic cyc(input logic iv, input logic wr, input logic [127:0] ci, output logic acc);
        issue_valid = iv;
        word_ready  = wr;
        core_in     = ci;
        acc         = iv && issue_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        logic acc;
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) cyc(1'b0, 1'b1, junk(), acc);
        chk(nm, exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard on handshakes, stall hold and credit bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_data", word_data, prev_data);
                chk("stall_hold_last", word_last, prev_last);
            end
            chk("credit_bound", (int'(dut.w_fifo_count) + int'(dut.r_inflight)) <= 4, 1);
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h, no word expected", word_data);
                end else begin
                    chk("word_data", word_data, exp_q[0].w);
                    chk("word_last", word_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall <= word_valid && !word_ready;
            prev_data  <= word_data;
            prev_last  <= word_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   i;
        int   waited;

        tab[0] = '{128'h3925841d02dc09fbdc118597196a0b32, 32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
        tab[1] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        tab[2] = '{128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 32'h66e94bd4, 32'hef8a2c3b, 32'h884cfa59, 32'hca342b2e};
        tab[3] = '{128'h0545aad56da2a97c3663d1432a3d1c84, 32'h0545aad5, 32'h6da2a97c, 32'h3663d143, 32'h2a3d1c84};
        tab[4] = '{128'h58e2fccefa7e3061367f1d57a4e7455a, 32'h58e2fcce, 32'hfa7e3061, 32'h367f1d57, 32'ha4e7455a};

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        issue_valid = 1'b0;
        word_ready  = 1'b0;
        core_in     = 128'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_last", word_last, 0);
        chk("rst_word_data", word_data, 0);
        rst_n = 1'b1;

        // Single FIPS-197 C.1 block: valid must rise exactly after edge N+11.
        cyc(1'b1, 1'b1, tab[1].ct, acc);
        chk("t1_accept", acc, 1);
        if (acc) exp_push(1);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1, junk(), acc);
            chk("t1_not_early", word_valid, 0);
        end
        cyc(1'b0, 1'b1, junk(), acc);
        chk("t1_valid_rise", word_valid, 1);
        chk("t1_word0", word_data, 32'h69c4e0d8);
        drain("t1_drain");

        // Five vectors back-to-back: credit runs out after four.
        i = 0;
        waited = 0;
        for (int c = 0; c < 200 && i < 5; c++) begin
            cyc(1'b1, 1'b1, tab[i].ct, acc);
            if (acc) begin
                exp_push(i);
                i++;
                if (i == 4) chk("t2_ready_drop", issue_ready, 0);
            end else begin
                waited++;
            end
        end
        chk("t2_all_issued", i, 5);
        chk("t2_throttled", waited > 0, 1);
        drain("t2_drain");

        // Consumer backpressure for 30 cycles with continuous issue attempts.
        i = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b1, 1'b0, tab[i % 5].ct, acc);
            if (acc) begin
                exp_push(i % 5);
                i++;
            end
        end
        chk("t3_accepted", i, 4);
        chk("t3_valid", word_valid, 1);
        chk("t3_hold_w0", word_data, tab[0].w0);
        chk("t3_ready_low", issue_ready, 0);
        drain("t3_drain");

        // Random consumer stalls during a 10-block stream.
        i = 0;
        for (int c = 0; c < 2000; c++) begin
            cyc(i < 10, 1'($urandom_range(0, 1)), (i < 10) ? tab[i % 5].ct : junk(), acc);
            if (acc) begin
                exp_push(i % 5);
                i++;
            end
            if (i == 10 && exp_q.size() == 0) break;
        end
        chk("t4_issued", i, 10);
        chk("t4_drained", exp_q.size(), 0);

        // Reset mid-flight: stale core results must never surface.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, tab[k].ct, acc);
            chk("t5_accept", acc, 1);
        end
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, junk(), acc);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_issue_ready", issue_ready, 1);
        chk("t5_rst_word_valid", word_valid, 0);
        chk("t5_rst_word_last", word_last, 0);
        chk("t5_rst_word_data", word_data, 0);
        cyc(1'b0, 1'b1, junk(), acc);
        cyc(1'b0, 1'b1, junk(), acc);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 1'b1, junk(), acc);
            chk("t5_no_stale", word_valid, 0);
        end
        chk("t5_ready_after", issue_ready, 1);
        cyc(1'b1, 1'b1, tab[2].ct, acc);
        chk("t5_fresh_accept", acc, 1);
        if (acc) exp_push(2);
        drain("t5_drain");

        // Capture of block B on the same edge as block A's word-3 handshake.
        cyc(1'b1, 1'b1, tab[3].ct, acc);
        if (acc) exp_push(3);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, junk(), acc);
        cyc(1'b1, 1'b1, tab[4].ct, acc);
        if (acc) exp_push(4);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, junk(), acc);
        chk("t6_pre_last", word_last, 1);
        chk("t6_pre_count", dut.w_fifo_count, 1);
        cyc(1'b0, 1'b1, junk(), acc);
        chk("t6_post_count", dut.w_fifo_count, 1);
        chk("t6_post_valid", word_valid, 1);
        chk("t6_next_w0", word_data, tab[4].w0);
        chk("t6_post_last", word_last, 0);
        drain("t6_drain");

        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, junk(), acc);
        chk("end_idle_valid", word_valid, 0);
        chk("end_idle_ready", issue_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
